// File: rtl/ppi_bus_pkg.sv
// Shared types and constants for the 8255A bus-cycle generator and its harness.
package ppi_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } ppi_state_e;

   localparam logic [1:0] PPI_PA   = 2'd0;
   localparam logic [1:0] PPI_PB   = 2'd1;
   localparam logic [1:0] PPI_PC   = 2'd2;
   localparam logic [1:0] PPI_CTRL = 2'd3;

   // Mode-0 control words: ports A, B, C all outputs / all inputs.
   localparam logic [7:0] PPI_CW_ALL_OUT = 8'h80;
   localparam logic [7:0] PPI_CW_ALL_IN  = 8'h9B;

endpackage

// File: rtl/ppi_bus_master.sv
// Single-beat host request to 8255A read/write bus cycle, all bus pins registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus released, req_ready high, accepts one request
// ST_SETUP  | cs_n and address valid ahead of the strobe
// ST_STROBE | rd_n or wr_n low; read data sampled on the last cycle
// ST_HOLD   | strobe released, cs_n/address/write data still held
module ppi_bus_master
   import ppi_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [1:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic [1:0] a,
   output logic [7:0] dbus_out,
   output logic       dbus_oe,
   input  logic [7:0] dbus_in
);

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

   ppi_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       write_q, write_d;
   logic [1:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       req_ready_q, req_ready_d;
   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       dbus_oe_q, dbus_oe_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = SETUP_LD;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               cnt_d   = STROBE_LD;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               // This edge is the rising edge of rd_n, so the peripheral data is still valid.
               if (!write_q) rdata_d = dbus_in;
               cnt_d   = HOLD_LD;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 4'd0) begin
               cnt_d       = 4'd0;
               rsp_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pins follow the next state so they change on the same edge as the state register.
      req_ready_d = (state_d == ST_IDLE);
      cs_n_d      = (state_d == ST_IDLE);
      dbus_oe_d   = (state_d != ST_IDLE) && write_d;
      rd_n_d      = !((state_d == ST_STROBE) && !write_d);
      wr_n_d      = !((state_d == ST_STROBE) && write_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         addr_q      <= 2'd0;
         wdata_q     <= 8'd0;
         rdata_q     <= 8'd0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         dbus_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         dbus_oe_q   <= dbus_oe_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign cs_n      = cs_n_q;
   assign rd_n      = rd_n_q;
   assign wr_n      = wr_n_q;
   assign a         = addr_q;
   assign dbus_out  = wdata_q;
   assign dbus_oe   = dbus_oe_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master: default timing instance plus a 1/1/1 timing instance.
module tb_ppi_bus_master;
   import ppi_bus_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       req_valid = 1'b0, req_write = 1'b0;
   logic [1:0] req_addr = 2'd0;
   logic [7:0] req_wdata = 8'd0, dbus_in = 8'hEE;
   logic       req_ready, rsp_valid, cs_n, rd_n, wr_n, dbus_oe;
   logic [7:0] rsp_rdata, dbus_out;
   logic [1:0] a;

   logic       m_req_valid = 1'b0, m_req_write = 1'b0;
   logic [1:0] m_req_addr = 2'd0;
   logic [7:0] m_req_wdata = 8'd0, m_dbus_in = 8'hEE;
   logic       m_req_ready, m_rsp_valid, m_cs_n, m_rd_n, m_wr_n, m_dbus_oe;
   logic [7:0] m_rsp_rdata, m_dbus_out;
   logic [1:0] m_a;

   int n_tot  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ppi_bus_master u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a(a),
      .dbus_out(dbus_out), .dbus_oe(dbus_oe), .dbus_in(dbus_in)
   );

   ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_min (
      .clk(clk), .rst(rst),
      .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(m_req_write),
      .req_addr(m_req_addr), .req_wdata(m_req_wdata),
      .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata),
      .cs_n(m_cs_n), .rd_n(m_rd_n), .wr_n(m_wr_n), .a(m_a),
      .dbus_out(m_dbus_out), .dbus_oe(m_dbus_oe), .dbus_in(m_dbus_in)
   );

   task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle k counts from the accept edge (k=1 is the first SETUP cycle) at default timing:
   // busy k=1..8, strobe k=3..6, rsp_valid k=9, read data visible from k=7.
   task automatic run_cyc(input string tag, input bit wr, input logic [1:0] ad,
                          input logic [7:0] wd, input logic [7:0] rv,
                          input logic [7:0] old_rd, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         bit busy, stb;
         busy = (k >= 1) && (k <= 8);
         stb  = (k >= 3) && (k <= 6);
         chk({tag, ".cs_n"}, k, 8'(cs_n), 8'(!busy));
         chk({tag, ".rd_n"}, k, 8'(rd_n), 8'(!(stb && !wr)));
         chk({tag, ".wr_n"}, k, 8'(wr_n), 8'(!(stb && wr)));
         chk({tag, ".dbus_oe"}, k, 8'(dbus_oe), 8'(busy && wr));
         chk({tag, ".rsp_valid"}, k, 8'(rsp_valid), 8'(k == 9));
         chk({tag, ".req_ready"}, k, 8'(req_ready), 8'(!busy));
         chk({tag, ".rsp_rdata"}, k, rsp_rdata, (!wr && k >= 7) ? rv : old_rd);
         if (busy) begin
            chk({tag, ".a"}, k, 8'(a), 8'(ad));
            chk({tag, ".dbus_out"}, k, dbus_out, wd);
         end
         dbus_in = stb ? rv : 8'hEE;
         tick();
      end
   endtask

   task automatic issue(input bit wr, input logic [1:0] ad, input logic [7:0] wd);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = ad;
      req_wdata = wd;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst.cs_n", 0, 8'(cs_n), 8'd1);
      chk("rst.rd_n", 0, 8'(rd_n), 8'd1);
      chk("rst.wr_n", 0, 8'(wr_n), 8'd1);
      chk("rst.a", 0, 8'(a), 8'd0);
      chk("rst.dbus_out", 0, dbus_out, 8'd0);
      chk("rst.dbus_oe", 0, 8'(dbus_oe), 8'd0);
      chk("rst.rsp_valid", 0, 8'(rsp_valid), 8'd0);
      chk("rst.rsp_rdata", 0, rsp_rdata, 8'd0);
      chk("rst.req_ready", 0, 8'(req_ready), 8'd1);
      tick();

      // Control-word write
      issue(1'b1, PPI_CTRL, PPI_CW_ALL_OUT);
      req_valid = 1'b0;
      req_wdata = 8'h00;
      run_cyc("wr", 1'b1, PPI_CTRL, PPI_CW_ALL_OUT, 8'h00, 8'h00, 1, 10);

      // Port B read
      issue(1'b0, PPI_PB, 8'h11);
      req_valid = 1'b0;
      run_cyc("rd", 1'b0, PPI_PB, 8'h11, 8'hA5, 8'h00, 1, 10);

      // Back-to-back: second request changes fields after the first accept
      issue(1'b1, PPI_PA, 8'h3C);
      req_write = 1'b0;
      req_addr  = PPI_PC;
      req_wdata = 8'h77;
      run_cyc("b2b_wr", 1'b1, PPI_PA, 8'h3C, 8'h00, 8'hA5, 1, 9);
      req_valid = 1'b0;
      run_cyc("b2b_rd", 1'b0, PPI_PC, 8'h77, 8'hC3, 8'hA5, 1, 10);

      // New request presented while busy must be ignored
      issue(1'b1, PPI_PB, 8'h55);
      req_valid = 1'b0;
      run_cyc("hold", 1'b1, PPI_PB, 8'h55, 8'h00, 8'hC3, 1, 2);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = PPI_PC;
      req_wdata = 8'hAA;
      run_cyc("hold", 1'b1, PPI_PB, 8'h55, 8'h00, 8'hC3, 3, 5);
      req_valid = 1'b0;
      run_cyc("hold", 1'b1, PPI_PB, 8'h55, 8'h00, 8'hC3, 6, 12);

      // Reset during the wr_n-low phase
      issue(1'b1, PPI_PA, 8'hF0);
      req_valid = 1'b0;
      run_cyc("mrst", 1'b1, PPI_PA, 8'hF0, 8'h00, 8'hC3, 1, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst.wr_n", 5, 8'(wr_n), 8'd1);
      chk("mrst.cs_n", 5, 8'(cs_n), 8'd1);
      chk("mrst.dbus_oe", 5, 8'(dbus_oe), 8'd0);
      chk("mrst.rsp_valid", 5, 8'(rsp_valid), 8'd0);
      chk("mrst.rsp_rdata", 5, rsp_rdata, 8'd0);
      chk("mrst.a", 5, 8'(a), 8'd0);
      tick();
      run_cyc("post_rst", 1'b1, PPI_PA, 8'hF0, 8'h00, 8'h00, 10, 14);
      issue(1'b0, PPI_PC, 8'h00);
      req_valid = 1'b0;
      run_cyc("post_rd", 1'b0, PPI_PC, 8'h00, 8'h69, 8'h00, 1, 10);

      // Minimum timing: SETUP, STROBE and HOLD each one cycle
      m_req_valid = 1'b1;
      m_req_write = 1'b0;
      m_req_addr  = PPI_CTRL;
      m_req_wdata = 8'h00;
      tick();
      m_req_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk("min.cs_n", k, 8'(m_cs_n), 8'(k > 3));
         chk("min.rd_n", k, 8'(m_rd_n), 8'(k != 2));
         chk("min.wr_n", k, 8'(m_wr_n), 8'd1);
         chk("min.dbus_oe", k, 8'(m_dbus_oe), 8'd0);
         chk("min.rsp_valid", k, 8'(m_rsp_valid), 8'(k == 4));
         chk("min.req_ready", k, 8'(m_req_ready), 8'(k > 3));
         chk("min.rsp_rdata", k, m_rsp_rdata, (k >= 3) ? 8'h5A : 8'h00);
         if (k <= 3) chk("min.a", k, 8'(m_a), 8'(PPI_CTRL));
         m_dbus_in = (k == 2) ? 8'h5A : 8'hEE;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
